// File: rtl/sram_async_ctrl.sv
// Sequencer for an external asynchronous SRAM: turns one valid/ready request into
// registered address, data, byte-lane, OE and WE pin activity with configurable timing.
`timescale 1ns/1ps
module sram_async_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURNAROUND = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_WIDTH-1:0]     sram_a,
  output logic [DATA_WIDTH-1:0]     sram_dq_out,
  output logic                      sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]     sram_dq_in,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [DATA_WIDTH/8-1:0]   sram_be_n
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int MAX_RW   = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int MAX_WAIT = (MAX_RW > TURNAROUND) ? MAX_RW : TURNAROUND;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CW-1:0] CNT_RD  = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] CNT_WR  = CW'(WRITE_WAIT - 1);
  localparam logic [CW-1:0] CNT_TA  = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_TURN     = 3'd5
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           cnt_r;
  logic                    ready_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [ADDR_WIDTH-1:0]   sram_a_r;
  logic [DATA_WIDTH-1:0]   dq_out_r;
  logic                    dq_oe_r;
  logic                    oe_n_r;
  logic                    we_n_r;
  logic [NB-1:0]           be_n_r;

  // Access sequencer; every pin strobe is a flop so WE/OE cannot glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      sram_a_r    <= {ADDR_WIDTH{1'b0}};
      dq_out_r    <= {DATA_WIDTH{1'b0}};
      dq_oe_r     <= 1'b0;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      be_n_r      <= {NB{1'b1}};
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            sram_a_r <= req_addr;
            dq_out_r <= req_wdata;
            be_n_r   <= ~req_be;
            ready_r  <= 1'b0;
            if (req_write) begin
              dq_oe_r <= 1'b1;
              state_r <= ST_WR_SETUP;
            end else begin
              oe_n_r  <= 1'b0;
              cnt_r   <= CNT_RD;
              state_r <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (cnt_r == CNT_ZERO) begin
            rsp_rdata_r <= sram_dq_in;
            rsp_valid_r <= 1'b1;
            oe_n_r      <= 1'b1;
            be_n_r      <= {NB{1'b1}};
            if (TURNAROUND > 0) begin
              cnt_r   <= CNT_TA;
              state_r <= ST_TURN;
            end else begin
              ready_r <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_TURN: begin
          if (cnt_r == CNT_ZERO) begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WR_SETUP: begin
          we_n_r  <= 1'b0;
          cnt_r   <= CNT_WR;
          state_r <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            we_n_r  <= 1'b1;
            state_r <= ST_WR_HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_WR_HOLD: begin
          // Data stays driven one cycle past the WE rising edge for hold time.
          dq_oe_r <= 1'b0;
          be_n_r  <= {NB{1'b1}};
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          dq_oe_r <= 1'b0;
          oe_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          be_n_r  <= {NB{1'b1}};
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign sram_a      = sram_a_r;
  assign sram_dq_out = dq_out_r;
  assign sram_dq_oe  = dq_oe_r;
  assign sram_oe_n   = oe_n_r;
  assign sram_we_n   = we_n_r;
  assign sram_be_n   = be_n_r;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: default instance against an SRAM pin model and a
// request-level memory model, plus a 32-bit / fast-timing parameter instance.
`timescale 1ns/1ps
module tb_sram_async_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;
  localparam int TA = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        req_valid, req_ready, req_write;
  logic [16:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [16:0] sram_a;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;

  logic        s_valid, s_ready, s_write;
  logic [16:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_rsp_valid;
  logic [31:0] s_rdata;
  logic [16:0] s_a;
  logic [31:0] s_dq_out, s_dq_in;
  logic        s_dq_oe, s_oe_n, s_we_n;
  logic [3:0]  s_be_n;

  sram_async_ctrl u0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_a(sram_a), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );

  sram_async_ctrl #(.ADDR_WIDTH(17), .DATA_WIDTH(32), .READ_WAIT(1),
                    .WRITE_WAIT(3), .TURNAROUND(0)) u1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_write(s_write),
    .req_addr(s_addr), .req_wdata(s_wdata), .req_be(s_be),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rdata),
    .sram_a(s_a), .sram_dq_out(s_dq_out), .sram_dq_oe(s_dq_oe),
    .sram_dq_in(s_dq_in), .sram_oe_n(s_oe_n), .sram_we_n(s_we_n),
    .sram_be_n(s_be_n)
  );

  int checks = 0;
  int errors = 0;

  // Power-up contents of the external part; one location is preloaded.
  function automatic logic [15:0] init_word(input logic [16:0] a);
    if (a == 17'h1_0004) return 16'hA5C3;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] lanes);
    logic [15:0] r;
    r = old_w;
    for (int i = 0; i < 2; i++) if (lanes[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Pin-level SRAM device for u0 (small sparse window of addresses).
  logic [15:0] dev_mem [64];
  bit          dev_wr  [64];

  function automatic int didx(input logic [16:0] a);
    return {26'd0, a[16], a[4:0]};
  endfunction

  function automatic logic [15:0] dev_rd(input logic [16:0] a);
    return dev_wr[didx(a)] ? dev_mem[didx(a)] : init_word(a);
  endfunction

  always @(posedge clk)
    if (reset_n === 1'b1 && sram_we_n === 1'b0 && sram_dq_oe === 1'b1) begin
      dev_mem[didx(sram_a)] <= merge(dev_rd(sram_a), sram_dq_out, ~sram_be_n);
      dev_wr[didx(sram_a)]  <= 1'b1;
    end

  always @(negedge clk) sram_dq_in <= dev_rd(sram_a);

  assign s_dq_in = {~s_a[15:0], s_a[15:0]};

  // Request-level reference memory.
  logic [15:0] ref_mem [logic [16:0]];

  function automatic logic [15:0] ref_rd(input logic [16:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [16:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", req_ready, 1'b1);
    req_write = wr; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    if (wr) ref_mem[a] = merge(ref_rd(a), d, be);
  endtask

  // Cycle k is the k-th cycle after the accepting edge.
  task automatic check_seq(input bit wr, input logic [16:0] a, input logic [15:0] d,
                           input logic [1:0] be, input logic [15:0] exp_rd);
    int L;
    bit occ, lanes_on;
    logic [1:0] be_exp;
    L = wr ? WW + 2 : RW + TA;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      occ = (k <= L);
      lanes_on = wr ? occ : (k <= RW);
      be_exp = lanes_on ? ~be : 2'b11;
      chk("ready", req_ready, !occ);
      chk("be_n", sram_be_n, be_exp);
      chk("no_oe_while_driving", sram_dq_oe && !sram_oe_n, 1'b0);
      chk("no_we_while_oe", !sram_we_n && !sram_oe_n, 1'b0);
      if (occ) chk("addr", sram_a, a);
      if (wr) begin
        chk("wr_dq_oe", sram_dq_oe, occ);
        chk("wr_we_n", sram_we_n, !(k >= 2 && k <= WW + 1));
        chk("wr_oe_n", sram_oe_n, 1'b1);
        chk("wr_rsp_valid", rsp_valid, 1'b0);
        if (occ) chk("wr_dq_out", sram_dq_out, d);
      end else begin
        chk("rd_oe_n", sram_oe_n, !(k <= RW));
        chk("rd_dq_oe", sram_dq_oe, 1'b0);
        chk("rd_we_n", sram_we_n, 1'b1);
        chk("rd_rsp_valid", rsp_valid, k == RW + 1);
        if (k == RW + 1 && be != 2'b00) chk("rd_data", rsp_rdata, exp_rd);
      end
    end
  endtask

  task automatic s_access(input bit wr, input logic [16:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    int n, L;
    bit occ;
    logic [3:0] be_exp;
    logic [31:0] exp_rd;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_wait_ready", s_ready, 1'b1);
    s_write = wr; s_addr = a; s_wdata = d; s_be = be; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    exp_rd = {~a[15:0], a[15:0]};
    L = wr ? 5 : 1;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      occ = (k <= L);
      be_exp = occ ? ~be : 4'hF;
      chk("s_ready", s_ready, !occ);
      chk("s_be_n", s_be_n, be_exp);
      chk("s_dq_oe", s_dq_oe, wr && occ);
      chk("s_oe_n", s_oe_n, wr ? 1'b1 : !(k == 1));
      chk("s_we_n", s_we_n, wr ? !(k >= 2 && k <= 4) : 1'b1);
      chk("s_rsp_valid", s_rsp_valid, !wr && k == 2);
      if (!wr && k == 2) chk("s_rd_data", s_rdata, exp_rd);
    end
  endtask

  logic [16:0] ra;
  logic [15:0] rd, expw, hi_exp;
  logic [1:0]  rbe;
  bit          rwr;

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    s_valid = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;

    // Reset values while reset is held.
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    chk("rst_a", sram_a, 17'h0_0000);
    chk("rst_dq_out", sram_dq_out, 16'h0000);
    chk("rst_dq_oe", sram_dq_oe, 1'b0);
    chk("rst_oe_n", sram_oe_n, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_be_n", sram_be_n, 2'b11);
    chk("s_rst_be_n", s_be_n, 4'hF);
    chk("s_rst_ready", s_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read of the preloaded word.
    expw = ref_rd(17'h1_0004);
    issue(1'b0, 17'h1_0004, 16'h0000, 2'b11, 1'b0);
    check_seq(1'b0, 17'h1_0004, 16'h0000, 2'b11, expw);
    chk("read_a5c3", rsp_rdata, 16'hA5C3);

    // Low-byte write then readback.
    hi_exp = init_word(17'h0_0010);
    issue(1'b1, 17'h0_0010, 16'hBEEF, 2'b01, 1'b0);
    check_seq(1'b1, 17'h0_0010, 16'hBEEF, 2'b01, 16'h0000);
    expw = ref_rd(17'h0_0010);
    issue(1'b0, 17'h0_0010, 16'h0000, 2'b11, 1'b0);
    check_seq(1'b0, 17'h0_0010, 16'h0000, 2'b11, expw);
    chk("rb_low", rsp_rdata[7:0], 8'hEF);
    chk("rb_high", rsp_rdata[15:8], hi_exp[15:8]);

    // Read then write with req_valid held high throughout.
    expw = ref_rd(17'h0_0003);
    issue(1'b0, 17'h0_0003, 16'h0000, 2'b11, 1'b1);
    req_write = 1'b1; req_addr = 17'h0_0005; req_wdata = 16'h1234; req_be = 2'b11;
    check_seq(1'b0, 17'h0_0003, 16'h0000, 2'b11, expw);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ref_mem[17'h0_0005] = 16'h1234;
    check_seq(1'b1, 17'h0_0005, 16'h1234, 2'b11, 16'h0000);

    // Randomized mix against the reference memory.
    for (int t = 0; t < 40; t++) begin
      rwr = 1'($urandom_range(0, 1));
      ra  = 17'($urandom_range(0, 15));
      rd  = 16'($urandom);
      rbe = 2'($urandom_range(0, 3));
      expw = ref_rd(ra);
      issue(rwr, ra, rd, rbe, 1'b0);
      check_seq(rwr, ra, rd, rbe, expw);
    end

    // Wide / fast instance.
    s_access(1'b0, 17'h0_0021, 32'h0, 4'hF);
    s_access(1'b0, 17'h0_1234, 32'h0, 4'h5);
    s_access(1'b1, 17'h0_0007, 32'hDEAD_BEEF, 4'hC);
    s_access(1'b0, 17'h1_FFFF, 32'h0, 4'hF);

    // Reset in the middle of the write pulse.
    issue(1'b1, 17'h1_001F, 16'h5555, 2'b11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_we_low", sram_we_n, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_we_n", sram_we_n, 1'b1);
    chk("async_dq_oe", sram_dq_oe, 1'b0);
    chk("async_be_n", sram_be_n, 2'b11);
    chk("async_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_a", sram_a, 17'h0_0000);
    chk("post_rst_rdata", rsp_rdata, 16'h0000);
    expw = ref_rd(17'h0_0002);
    issue(1'b0, 17'h0_0002, 16'h0000, 2'b10, 1'b0);
    check_seq(1'b0, 17'h0_0002, 16'h0000, 2'b10, expw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
